// File: rtl/m_div_seq.sv
// Restoring 1-bit/cycle divider for DIV/DIVU/REM/REMU and, on RV64, the word forms.
// Operands are captured on the accepting edge so the core may move on while this unit is busy.
module m_div_seq #(
    parameter int XLEN      = 32,
    parameter int SUPPORT_W = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_f3,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_res,
    output logic            o_done,
    output logic            o_busy
);

    // state  | meaning
    // S_IDLE | waiting for a start
    // S_CALC | one quotient bit per cycle, cnt counts down to zero
    // S_FIX  | apply result signs and word sign-extension
    // S_DONE | o_done pulse; a new start may be accepted here

    localparam bit USE_W = (SUPPORT_W != 0) && (XLEN == 64);
    localparam int CW    = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic            is_rem_r;
    logic            word_r;
    logic            neg_q_r;
    logic            neg_r_r;

    logic            w_op;
    logic            sgn;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] min_v;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] fmt_a;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]   rem_sh;
    logic            fits;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] q_nx;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] sel_res;
    logic [XLEN-1:0] fix_res;

    logic            unused_f3;
    assign unused_f3 = i_f3[2];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    always_comb begin
        w_op     = USE_W && i_word;
        sgn      = ~i_f3[0];
        a_ext    = i_rs1;
        b_ext    = i_rs2;
        if (w_op) begin
            a_ext = sgn ? sext32(i_rs1[31:0]) : XLEN'(i_rs1[31:0]);
            b_ext = sgn ? sext32(i_rs2[31:0]) : XLEN'(i_rs2[31:0]);
        end
        a_neg    = sgn & a_ext[XLEN-1];
        b_neg    = sgn & b_ext[XLEN-1];
        abs_a    = a_neg ? -a_ext : a_ext;
        abs_b    = b_neg ? -b_ext : b_ext;
        min_v    = w_op ? ~XLEN'(32'h7fff_ffff) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = sgn && (a_ext == min_v) && (b_ext == '1);
        fmt_a    = w_op ? sext32(i_rs1[31:0]) : i_rs1;
        if (div_zero) begin
            spec_res = i_f3[1] ? fmt_a : '1;
        end else begin
            spec_res = i_f3[1] ? '0 : fmt_a;
        end
    end

    // Word ops are left-aligned in q so the same shifter finishes them in 32 steps.
    always_comb begin
        rem_sh  = {rem, q[XLEN-1]};
        fits    = rem_sh >= {1'b0, dvs};
        rem_nx  = fits ? XLEN'(rem_sh - {1'b0, dvs}) : rem_sh[XLEN-1:0];
        q_nx    = {q[XLEN-2:0], fits};
        q_fix   = neg_q_r ? -q : q;
        r_fix   = neg_r_r ? -rem : rem;
        sel_res = is_rem_r ? r_fix : q_fix;
        fix_res = word_r ? sext32(sel_res[31:0]) : sel_res;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            q        <= '0;
            rem      <= '0;
            dvs      <= '0;
            is_rem_r <= 1'b0;
            word_r   <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            o_res    <= '0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    if (i_start && !i_kill) begin
                        is_rem_r <= i_f3[1];
                        word_r   <= w_op;
                        neg_q_r  <= a_neg ^ b_neg;
                        neg_r_r  <= a_neg;
                        if (div_zero || ovf) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_res  <= spec_res;
                        end else begin
                            state  <= S_CALC;
                            o_busy <= 1'b1;
                            cnt    <= w_op ? CW'(31) : CW'(XLEN - 1);
                            q      <= w_op ? (abs_a << (XLEN - 32)) : abs_a;
                            rem    <= '0;
                            dvs    <= abs_b;
                        end
                    end
                end
                S_CALC: begin
                    if (i_kill) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        q   <= q_nx;
                        rem <= rem_nx;
                        if (cnt == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    state  <= i_kill ? S_IDLE : S_DONE;
                    o_busy <= 1'b0;
                    if (!i_kill) begin
                        o_done <= 1'b1;
                        o_res  <= fix_res;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_div_seq.sv
// Bench for m_div_seq: a 32-bit instance and a 64-bit instance with word ops, each
// checked every cycle against a transaction-level arithmetic model, plus directed literals.
module tb_m_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_kill, a_word;
    logic [2:0]  a_f3;
    logic [31:0] a_rs1, a_rs2, a_res;
    logic        a_done, a_busy;
    logic        b_start, b_kill, b_word;
    logic [2:0]  b_f3;
    logic [63:0] b_rs1, b_rs2, b_res;
    logic        b_done, b_busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    m_div_seq #(.XLEN(32), .SUPPORT_W(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_kill(a_kill), .i_f3(a_f3),
        .i_word(a_word), .i_rs1(a_rs1), .i_rs2(a_rs2), .o_res(a_res), .o_done(a_done),
        .o_busy(a_busy));

    m_div_seq #(.XLEN(64), .SUPPORT_W(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_kill(b_kill), .i_f3(b_f3),
        .i_word(b_word), .i_rs1(b_rs1), .i_rs2(b_rs2), .o_res(b_res), .o_done(b_done),
        .o_busy(b_busy));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input int w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        m = wmask(w);
        a &= m;
        b &= m;
        return (b == 0) || (!f3[0] && a == (64'd1 << (w - 1)) && b == m);
    endfunction

    // Architectural result: plain SV arithmetic, truncating division.
    function automatic logic [63:0] ref_div(input logic [2:0] f3, input bit word, input int xlen,
                                            input logic [63:0] a, input logic [63:0] b);
        int w;
        logic [63:0] m, r;
        longint sa, sb;
        w = word ? 32 : xlen;
        m = wmask(w);
        a &= m;
        b &= m;
        if (b == 0) begin
            r = f3[1] ? a : m;
        end else if (!f3[0] && a == (64'd1 << (w - 1)) && b == m) begin
            r = f3[1] ? 64'd0 : a;
        end else if (!f3[0]) begin
            sa = (w == 32) ? longint'($signed(a[31:0])) : $signed(a);
            sb = (w == 32) ? longint'($signed(b[31:0])) : $signed(b);
            r  = f3[1] ? 64'(sa % sb) : 64'(sa / sb);
        end else begin
            r = f3[1] ? a % b : a / b;
        end
        r &= m;
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r & wmask(xlen);
    endfunction

    typedef struct {
        bit          pend;
        int          remain;
        logic [63:0] pres;
        bit          done;
        bit          busy;
        logic [63:0] res;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input bit rst_n, input bit start, input bit kill,
                                      input logic [2:0] f3, input bit word, input int xlen,
                                      input logic [63:0] a, input logic [63:0] b);
        mdl_t n;
        int w;
        n = m;
        n.done = 1'b0;
        w = word ? 32 : xlen;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        if (m.pend) begin
            if (kill) begin
                n.pend = 1'b0;
            end else begin
                n.remain = m.remain - 1;
                if (n.remain == 0) begin
                    n.pend = 1'b0;
                    n.done = 1'b1;
                    n.res  = m.pres;
                end
            end
        end else if (start && !kill) begin
            if (is_special(f3, w, a, b)) begin
                n.done = 1'b1;
                n.res  = ref_div(f3, word, xlen, a, b);
            end else begin
                n.pend   = 1'b1;
                n.remain = w + 1;
                n.pres   = ref_div(f3, word, xlen, a, b);
            end
        end
        n.busy = n.pend;
        return n;
    endfunction

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    always @(posedge clk) begin
        ma = mdl_step(ma, rst, a_start, a_kill, a_f3, 1'b0, 32, {32'b0, a_rs1}, {32'b0, a_rs2});
        mb = mdl_step(mb, rst, b_start, b_kill, b_f3, b_word, 64, b_rs1, b_rs2);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_done", a_done, ma.done);
            chk("a_busy", a_busy, ma.busy);
            chk("a_res", a_res, ma.res);
            chk("b_done", b_done, mb.done);
            chk("b_busy", b_busy, mb.busy);
            chk("b_res", b_res, mb.res);
        end
    end

    task automatic drive(input bit sel, input bit st, input logic [2:0] f3, input bit word,
                         input logic [63:0] r1, input logic [63:0] r2);
        if (sel) begin
            b_start = st; b_f3 = f3; b_word = word; b_rs1 = r1; b_rs2 = r2;
        end else begin
            a_start = st; a_f3 = f3; a_rs1 = r1[31:0]; a_rs2 = r2[31:0];
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 7)
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Launch one op and measure edges from accept until o_done is seen.
    task automatic do_op(input bit sel, input logic [2:0] f3, input bit word, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] exp_res, input int exp_lat,
                         input string name, input bit noisy);
        int lat;
        logic [63:0] res;
        lat = 0;
        res = 'x;
        drive(sel, 1'b1, f3, word, rs1, rs2);
        @(posedge clk); #1;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            if (noisy && c < exp_lat) drive(sel, 1'b1, 3'($urandom), 1'b0, pick(), pick());
            else drive(sel, 1'b0, 3'b0, 1'b0, 64'd0, 64'd0);
            @(negedge clk);
            if (sel ? b_done : a_done) begin
                lat = c;
                res = sel ? b_res : {32'b0, a_res};
            end
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 3'b0, 1'b0, 64'd0, 64'd0);
        chk({name, " res"}, res, exp_res);
        chk({name, " lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic abort_test(input bit use_rst, input string name);
        int seen;
        seen = 0;
        drive(1'b0, 1'b1, 3'b100, 1'b0, 64'd1000, 64'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b0, 1'b0, 64'd0, 64'd0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        if (use_rst) rst = 1'b0;
        else a_kill = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        a_kill = 1'b0;
        @(negedge clk);
        chk({name, " busy"}, a_busy, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done) seen++;
        end
        chk({name, " no done"}, 64'(seen), 64'd0);
        @(posedge clk); #1;
        do_op(1'b0, 3'b001, 1'b0, 64'd100, 64'd7, 64'd14, 34, {name, " then divu"}, 1'b0);
    endtask

    initial begin
        logic [63:0] t1, t2;
        rst = 1'b0;
        a_start = 0; a_kill = 0; a_word = 0; a_f3 = 0; a_rs1 = 0; a_rs2 = 0;
        b_start = 0; b_kill = 0; b_word = 0; b_f3 = 0; b_rs1 = 0; b_rs2 = 0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset res", {32'b0, a_res}, 64'd0);
        chk("reset done", a_done, 1'b0);
        chk("reset busy", a_busy, 1'b0);
        @(posedge clk); #1;

        do_op(0, 3'b000, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 34, "div -7/2", 0);
        do_op(0, 3'b010, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 34, "rem -7/2", 0);
        do_op(0, 3'b001, 0, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF, 1, "divu by 0", 0);
        do_op(0, 3'b010, 0, 64'd5, 64'd0, 64'd5, 1, "rem 5/0", 0);
        do_op(0, 3'b000, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div ovf", 0);
        do_op(0, 3'b010, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, "rem ovf", 0);
        do_op(0, 3'b011, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 34, "remu big", 0);
        do_op(0, 3'b000, 0, 64'd1000, 64'hFFFF_FFF9, 64'hFFFF_FF72, 34, "div noisy", 1);
        abort_test(1'b0, "kill");
        abort_test(1'b1, "reset");

        a_start = 1'b1; a_kill = 1'b1; a_f3 = 3'b001; a_rs1 = 32'd9; a_rs2 = 32'd2;
        @(posedge clk); #1;
        a_start = 1'b0; a_kill = 1'b0;
        @(negedge clk);
        chk("start+kill busy", a_busy, 1'b0);
        chk("start+kill done", a_done, 1'b0);
        @(posedge clk); #1;

        do_op(1, 3'b000, 1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34, "divw", 0);
        do_op(1, 3'b001, 0, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_C000_0000, 66, "divu64", 0);
        do_op(1, 3'b011, 1, 64'h0000_0000_FFFF_FFFF, 64'd16, 64'd15, 34, "remuw", 0);

        for (int i = 0; i < 3000; i++) begin
            a_start = ($urandom % 3) == 0;
            a_kill  = ($urandom % 100) == 0;
            a_f3    = 3'($urandom);
            t1 = pick(); t2 = pick();
            a_rs1 = t1[31:0]; a_rs2 = t2[31:0];
            b_start = ($urandom % 3) == 0;
            b_kill  = ($urandom % 100) == 0;
            b_f3    = 3'($urandom);
            b_word  = 1'($urandom);
            b_rs1 = pick(); b_rs2 = pick();
            rst = ($urandom % 700) != 0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        a_start = 0; a_kill = 0; b_start = 0; b_kill = 0;
        repeat (80) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
